game_mode_controller: RTL and testbench

- Top-level game-mode FSM sitting directly upstream of the start-sequence block.
- Turns a raw start button into the start-sequence enable (STARTen) and waits for that block's RUNen handshake.
- Then gates the running game, counts score, detects game over and keeps a high score.
- Also drives the display-source select for the LED-matrix mux.

---
 rtl/game_mode_controller.sv | 168 ++++++++++++++++
 tb/tb_game_mode_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_mode_controller.sv
// Game-mode sequencer: button synchronizer, start-sequence handshake, run/over gating,
// score and high-score keeping, and display-source selection for the LED-matrix mux.
module game_mode_controller #(
    parameter int SCORE_W   = 8,
    parameter int OVER_HOLD = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               KEY_START,
    input  logic               RUNen,
    input  logic               COLLIDE,
    input  logic               TICK,
    output logic               STARTen,
    output logic               GAMEen,
    output logic               GAMEOVER,
    output logic [1:0]         PixSEL,
    output logic [SCORE_W-1:0] SCORE,
    output logic [SCORE_W-1:0] HISCORE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [3:0]         HOLD_MAX  = 4'(OVER_HOLD);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [2:0]         sync_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hiscore_q, hiscore_d;
    logic [3:0]         hold_q, hold_d;
    logic               starten_q, starten_d;
    logic               gameen_q, gameen_d;
    logic               gameover_q, gameover_d;
    logic [1:0]         pixsel_q, pixsel_d;
    logic               press_s;

    // sync_q[0..1] resynchronise the button, sync_q[2] delays it for edge detection
    assign press_s = sync_q[1] & ~sync_q[2];

    // State, button synchronizer and score/hold datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            sync_q    <= 3'b000;
            score_q   <= '0;
            hiscore_q <= '0;
            hold_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[1:0], KEY_START};
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state and datapath update rules
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (press_s) begin
                    state_d = ST_START;
                    score_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (RUNen) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_RUN: begin
                // a collision wins over a coincident tick; the pre-collision score is final
                if (COLLIDE) begin
                    state_d = ST_OVER;
                    hold_d  = 4'd0;
                    if (score_q > hiscore_q) begin
                        hiscore_d = score_q;
                    end else begin
                        hiscore_d = hiscore_q;
                    end
                end else if (TICK && (score_q != SCORE_MAX)) begin
                    score_d = score_q + SCORE_ONE;
                end else begin
                    score_d = score_q;
                end
            end
            ST_OVER: begin
                if (press_s && (hold_q == HOLD_MAX)) begin
                    state_d = ST_START;
                    score_d = '0;
                end else if (TICK && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the upcoming state so outputs move with the state
    always_comb begin
        starten_d  = 1'b0;
        gameen_d   = 1'b0;
        gameover_d = 1'b0;
        pixsel_d   = 2'd0;
        case (state_d)
            ST_IDLE: begin
                pixsel_d = 2'd0;
            end
            ST_START: begin
                starten_d = 1'b1;
                pixsel_d  = 2'd1;
            end
            ST_RUN: begin
                starten_d = 1'b1;
                gameen_d  = 1'b1;
                pixsel_d  = 2'd2;
            end
            ST_OVER: begin
                gameover_d = 1'b1;
                pixsel_d   = 2'd3;
            end
            default: begin
                pixsel_d = 2'd0;
            end
        endcase
    end

    // Registered control outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starten_q  <= 1'b0;
            gameen_q   <= 1'b0;
            gameover_q <= 1'b0;
            pixsel_q   <= 2'd0;
        end else begin
            starten_q  <= starten_d;
            gameen_q   <= gameen_d;
            gameover_q <= gameover_d;
            pixsel_q   <= pixsel_d;
        end
    end

    assign STARTen  = starten_q;
    assign GAMEen   = gameen_q;
    assign GAMEOVER = gameover_q;
    assign PixSEL   = pixsel_q;
    assign SCORE    = score_q;
    assign HISCORE  = hiscore_q;

endmodule

// File: tb/tb_game_mode_controller.sv
// Bench for game_mode_controller: directed scenario plus random play, checked every cycle
// against a mode-level model for an 8-bit and a 3-bit score instance.
module tb_game_mode_controller;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic KEY_START = 1'b0;
    logic RUNen = 1'b0;
    logic COLLIDE = 1'b0;
    logic TICK = 1'b0;

    logic       st8, ge8, go8, st3, ge3, go3;
    logic [1:0] pix8, pix3;
    logic [7:0] sc8, hi8;
    logic [2:0] sc3, hi3;

    int errors = 0;
    int checks = 0;
    bit running = 1'b1;

    localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_OVER = 3;

    typedef struct packed {
        int mode;
        int sc8;
        int sc3;
        int hi8;
        int hi3;
        int hold;
        int k1;
        int k2;
        int k3;
    } model_t;

    model_t m = '0;

    game_mode_controller #(.SCORE_W(8), .OVER_HOLD(4)) dut8 (
        .CLK(CLK), .RST(RST), .KEY_START(KEY_START), .RUNen(RUNen),
        .COLLIDE(COLLIDE), .TICK(TICK), .STARTen(st8), .GAMEen(ge8),
        .GAMEOVER(go8), .PixSEL(pix8), .SCORE(sc8), .HISCORE(hi8)
    );

    game_mode_controller #(.SCORE_W(3), .OVER_HOLD(4)) dut3 (
        .CLK(CLK), .RST(RST), .KEY_START(KEY_START), .RUNen(RUNen),
        .COLLIDE(COLLIDE), .TICK(TICK), .STARTen(st3), .GAMEen(ge3),
        .GAMEOVER(go3), .PixSEL(pix3), .SCORE(sc3), .HISCORE(hi3)
    );

    always #5 CLK = ~CLK;

    // k1/k2/k3 hold the key seen 1/2/3 edges ago; a press lands two edges after the key rises
    function automatic model_t step_model(model_t c, int key, int runen, int col, int tick);
        model_t n = c;
        bit press = (c.k2 == 1) && (c.k3 == 0);
        n.k1 = key;
        n.k2 = c.k1;
        n.k3 = c.k2;
        if (c.mode == M_IDLE) begin
            if (press) begin n.mode = M_START; n.sc8 = 0; n.sc3 = 0; end
        end else if (c.mode == M_START) begin
            if (runen != 0) n.mode = M_RUN;
        end else if (c.mode == M_RUN) begin
            if (col != 0) begin
                n.mode = M_OVER;
                n.hold = 0;
                n.hi8 = (c.sc8 > c.hi8) ? c.sc8 : c.hi8;
                n.hi3 = (c.sc3 > c.hi3) ? c.sc3 : c.hi3;
            end else if (tick != 0) begin
                n.sc8 = (c.sc8 < 255) ? c.sc8 + 1 : 255;
                n.sc3 = (c.sc3 < 7) ? c.sc3 + 1 : 7;
            end
        end else begin
            if (press && c.hold == 4) begin
                n.mode = M_START; n.sc8 = 0; n.sc3 = 0;
            end else if (tick != 0 && c.hold < 4) begin
                n.hold = c.hold + 1;
            end
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) m <= '0;
        else m <= step_model(m, int'(KEY_START), int'(RUNen), int'(COLLIDE), int'(TICK));
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (running) begin
            chk("STARTen8", int'(st8), int'(m.mode == M_START || m.mode == M_RUN));
            chk("GAMEen8", int'(ge8), int'(m.mode == M_RUN));
            chk("GAMEOVER8", int'(go8), int'(m.mode == M_OVER));
            chk("PixSEL8", int'(pix8), m.mode);
            chk("SCORE8", int'(sc8), m.sc8);
            chk("HISCORE8", int'(hi8), m.hi8);
            chk("STARTen3", int'(st3), int'(m.mode == M_START || m.mode == M_RUN));
            chk("GAMEen3", int'(ge3), int'(m.mode == M_RUN));
            chk("GAMEOVER3", int'(go3), int'(m.mode == M_OVER));
            chk("PixSEL3", int'(pix3), m.mode);
            chk("SCORE3", int'(sc3), m.sc3);
            chk("HISCORE3", int'(hi3), m.hi3);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin @(posedge CLK); #3; end
    endtask

    task automatic ticks(int n);
        repeat (n) begin TICK = 1'b1; cyc(1); TICK = 1'b0; cyc(1); end
    endtask

    task automatic press_key();
        KEY_START = 1'b1; cyc(3); KEY_START = 1'b0; cyc(2);
    endtask

    task automatic collide();
        COLLIDE = 1'b1; cyc(1); COLLIDE = 1'b0; cyc(1);
    endtask

    task automatic run_en();
        RUNen = 1'b1; cyc(1); RUNen = 1'b0;
    endtask

    initial begin
        cyc(3);
        chk("rst_STARTen", int'(st8), 0);
        chk("rst_PixSEL", int'(pix8), 0);
        chk("rst_SCORE", int'(sc8), 0);
        RST = 1'b1;
        cyc(2);

        KEY_START = 1'b1;
        cyc(2);
        chk("press_k1_STARTen", int'(st8), 0);
        cyc(1);
        chk("press_k2_STARTen", int'(st8), 1);
        chk("press_k2_PixSEL", int'(pix8), 1);
        cyc(20);
        chk("hold_key_PixSEL", int'(pix8), 1);
        KEY_START = 1'b0;

        COLLIDE = 1'b1; TICK = 1'b1; cyc(1);
        COLLIDE = 1'b0; TICK = 1'b0; cyc(1);
        chk("start_collide_PixSEL", int'(pix8), 1);
        run_en();
        chk("run_GAMEen", int'(ge8), 1);
        chk("run_PixSEL", int'(pix8), 2);

        ticks(5);
        chk("model_score5", m.sc8, 5);
        COLLIDE = 1'b1; TICK = 1'b1; cyc(1);
        COLLIDE = 1'b0; TICK = 1'b0; cyc(1);
        chk("over_SCORE", int'(sc8), 5);
        chk("over_GAMEOVER", int'(go8), 1);
        chk("over_STARTen", int'(st8), 0);
        chk("over_HISCORE", int'(hi8), 5);

        ticks(2);
        KEY_START = 1'b1; cyc(4); KEY_START = 1'b0; cyc(4);
        chk("early_press_GAMEOVER", int'(go8), 1);
        ticks(2);
        KEY_START = 1'b1; cyc(3);
        chk("restart_PixSEL", int'(pix8), 1);
        chk("restart_SCORE", int'(sc8), 0);
        chk("restart_HISCORE", int'(hi8), 5);
        KEY_START = 1'b0; cyc(2);
        run_en();
        ticks(3);
        collide();
        chk("game2_SCORE", int'(sc8), 3);
        chk("game2_HISCORE", int'(hi8), 5);

        ticks(4); press_key(); run_en();
        ticks(9);
        chk("sat_SCORE3", int'(sc3), 7);
        chk("sat_SCORE8", int'(sc8), 9);
        collide();
        chk("sat_HISCORE3", int'(hi3), 7);
        chk("model_hi3", m.hi3, 7);

        ticks(4); press_key(); run_en();
        ticks(4);
        chk("pre_rst_SCORE", int'(sc8), 4);
        #1 RST = 1'b0;
        #1;
        chk("arst_STARTen", int'(st8), 0);
        chk("arst_GAMEen", int'(ge8), 0);
        chk("arst_PixSEL", int'(pix8), 0);
        chk("arst_SCORE", int'(sc8), 0);
        chk("arst_HISCORE", int'(hi8), 0);
        @(posedge CLK); #3;
        RST = 1'b1;
        cyc(2);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) KEY_START = ~KEY_START;
            RUNen   = ($urandom_range(0, 3) == 0);
            COLLIDE = ($urandom_range(0, 29) == 0);
            TICK    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 699) == 0) begin
                RST = 1'b0; cyc(1); RST = 1'b1;
            end else begin
                cyc(1);
            end
        end

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
